// File: rtl/tri_bus_arb_pkg.sv
// Shared types and helpers for the tri_bus_arb round-robin bus arbiter.
package tri_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRIVE,
        ST_TURN
    } arb_state_t;

    localparam int unsigned TURN_CYCLES = 1;
    localparam int unsigned MAX_REQ     = 32;

    // Callers size-cast the result down to their own request width.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/tri_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr, wrapping.
module rr_pick
    import tri_bus_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] win,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        win   = '0;
        found = 1'b0;
        cand  = '0;
        // Scan farthest-first so the nearest candidate to rr_ptr overwrites the others.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arb.sv
// Round-robin arbiter/sequencer for a shared tri-state bus: GRANT setup, bounded DRIVE, TURN gap.
// Optional trireg-style keeper enabled by defining TRI_BUS_ARB_KEEPER_EN.
module tri_bus_arb
    import tri_bus_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] bus_in,
    output logic [N_REQ-1:0]  grant,
    output logic [N_REQ-1:0]  oe,
    output logic              busy,
    output logic [DATA_W-1:0] keep_val,
    output logic              keep_vld
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);

    arb_state_t        state, state_d;
    logic [IDX_W-1:0]  win_idx, win_d;
    logic [IDX_W-1:0]  rr_ptr, ptr_d;
    logic [CNT_W-1:0]  burst_cnt, cnt_d;
    logic [TURN_W-1:0] turn_cnt, turn_d;
    logic [N_REQ-1:0]  grant_d, oe_d;
    logic [IDX_W-1:0]  pick_win;
    logic              pick_found;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (pick_win),
        .found  (pick_found)
    );

    always_comb begin
        state_d = state;
        win_d   = win_idx;
        ptr_d   = rr_ptr;
        cnt_d   = burst_cnt;
        turn_d  = turn_cnt;
        grant_d = grant;
        oe_d    = oe;
        unique case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    win_d   = pick_win;
                    grant_d = N_REQ'(onehot(32'(pick_win)));
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                state_d = ST_DRIVE;
                oe_d    = grant;
                cnt_d   = CNT_W'(1);
            end
            ST_DRIVE: begin
                if (!req[win_idx] || burst_cnt == CNT_W'(MAX_BURST)) begin
                    state_d = ST_TURN;
                    grant_d = '0;
                    oe_d    = '0;
                    ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    turn_d  = TURN_W'(1);
                end else begin
                    cnt_d = burst_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_cnt == TURN_W'(TURN_CYCLES)) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_idx   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            turn_cnt  <= '0;
            grant     <= '0;
            oe        <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values, like real flops.
            state     <= state_d;
            win_idx   <= win_d;
            rr_ptr    <= ptr_d;
            burst_cnt <= cnt_d;
            turn_cnt  <= turn_d;
            grant     <= grant_d;
            oe        <= oe_d;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef TRI_BUS_ARB_KEEPER_EN
    // Charge-hold emulation: only reset clears the kept value, never the bus floating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keep_val <= '0;
            keep_vld <= 1'b0;
        end else if (state == ST_DRIVE) begin
            keep_val <= bus_in;
            keep_vld <= 1'b1;
        end
    end
`else
    logic unused_bus;

    assign keep_val   = '0;
    assign keep_vld   = 1'b0;
    assign unused_bus = ^bus_in;
`endif

endmodule

// File: tb/tb_tri_bus_arb.sv
// Self-checking bench for tri_bus_arb: directed scenarios plus randomized tenures vs a tenure-level model.
module tb_tri_bus_arb;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
`ifdef TRI_BUS_ARB_KEEPER_EN
    localparam bit KEEPER = 1'b1;
`else
    localparam bit KEEPER = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N_REQ-1:0]  req;
    logic [DATA_W-1:0] bus_in;
    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  oe;
    logic              busy;
    logic [DATA_W-1:0] keep_val;
    logic              keep_vld;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ptr_m   = 0;
    logic [7:0]  keep_v_m = '0;
    logic        keep_ok_m = 1'b0;

    tri_bus_arb #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bus_in   (bus_in),
        .grant    (grant),
        .oe       (oe),
        .busy     (busy),
        .keep_val (keep_val),
        .keep_vld (keep_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_keep(input string tag);
        check({tag, " keep_val"}, 32'(keep_val), KEEPER ? 32'(keep_v_m) : 32'd0);
        check({tag, " keep_vld"}, 32'(keep_vld), KEEPER ? 32'(keep_ok_m) : 32'd0);
    endtask

    // Spec rule: first requesting index at or above the pointer, wrapping.
    function automatic int pick(input logic [3:0] pat, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (((pat >> ((p + k) % N_REQ)) & 4'd1) != 4'd0) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) begin
            bus_in = 8'($urandom);
            tick();
            check($sformatf("idle%0d grant", i), 32'(grant), 32'd0);
            check($sformatf("idle%0d oe", i), 32'(oe), 32'd0);
            check($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
            check_keep($sformatf("idle%0d", i));
        end
    endtask

    // One whole tenure from IDLE. The winner releases its request from cycle drop_at on
    // (0 = GRANT, j = j-th DRIVE); the DRIVE length follows as min(max(drop_at,1), MAX_BURST).
    task automatic tenure(input logic [3:0] pat, input int drop_at,
                          input logic [7:0] v1, input logic [7:0] vn);
        int         w;
        int         d;
        logic [3:0] oh;
        string      t;
        w  = pick(pat, ptr_m);
        d  = (drop_at < 1) ? 1 : drop_at;
        if (d > MAX_BURST) d = MAX_BURST;
        oh = 4'(1 << w);
        req    = pat;
        bus_in = 8'($urandom);
        for (int c = 0; c <= d + 2; c++) begin
            @(posedge clk);
            if (c - 1 >= 1 && c - 1 <= d) begin
                keep_v_m  = bus_in;
                keep_ok_m = 1'b1;
            end
            #1;
            t = $sformatf("w%0d c%0d", w, c);
            check({t, " grant"}, 32'(grant), (c <= d) ? 32'(oh) : 32'd0);
            check({t, " oe"}, 32'(oe), (c >= 1 && c <= d) ? 32'(oh) : 32'd0);
            check({t, " busy"}, 32'(busy), (c <= d + 1) ? 32'd1 : 32'd0);
            check_keep(t);
            req    = (c >= drop_at) ? (pat & ~oh) : pat;
            bus_in = (c == 1) ? v1 : ((c >= 2 && c <= d) ? vn : 8'($urandom));
        end
        ptr_m = (w + 1) % N_REQ;
        req   = '0;
    endtask

    initial begin
        int         w;
        logic [3:0] pat;

        rst    = 1'b1;
        req    = '0;
        bus_in = '0;
        #3;
        check("reset grant", 32'(grant), 32'd0);
        check("reset oe", 32'(oe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check_keep("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Round-robin fairness: winners 0,1,2,3,0 with 3-cycle oe gaps.
        for (int i = 0; i < 5; i++) tenure(4'b1111, 99, 8'($urandom), 8'($urandom));

        // Single requester repeated; pointer ends at 2.
        tenure(4'b0010, 99, 8'($urandom), 8'($urandom));
        tenure(4'b0010, 99, 8'($urandom), 8'($urandom));

        // Wrap-around: after driver 2 the pointer is 3, so 0011 must go to driver 0.
        tenure(4'b0100, 99, 8'($urandom), 8'($urandom));
        tenure(4'b0011, 99, 8'($urandom), 8'($urandom));

        // Early release in 2nd DRIVE cycle, and release during GRANT.
        tenure(4'b0001, 2, 8'($urandom), 8'($urandom));
        tenure(4'b0001, 0, 8'($urandom), 8'($urandom));

        // Keeper: A5 then 3C during DRIVE, held through idle.
        tenure(4'b0001, 2, 8'hA5, 8'h3C);
        idle(10);
        check("keeper final val", 32'(keep_val), KEEPER ? 32'h3C : 32'd0);
        check("keeper final vld", 32'(keep_vld), KEEPER ? 32'd1 : 32'd0);

        // Asynchronous reset inside DRIVE.
        req = 4'b0100;
        w   = pick(4'b0100, ptr_m);
        tick();
        tick();
        check("pre-reset oe", 32'(oe), 32'(1 << w));
        #2;
        rst = 1'b1;
        #1;
        check("async rst grant", 32'(grant), 32'd0);
        check("async rst oe", 32'(oe), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst keep_vld", 32'(keep_vld), 32'd0);
        check("async rst keep_val", 32'(keep_val), 32'd0);
        #1;
        rst       = 1'b0;
        req       = '0;
        ptr_m     = 0;
        keep_v_m  = '0;
        keep_ok_m = 1'b0;
        tenure(4'b1000, 99, 8'($urandom), 8'($urandom));

        // Randomized tenures with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            pat = 4'($urandom_range(1, 15));
            tenure(pat, int'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
